// File: rtl/vga_draw_pkg.sv
// ---------------------------------------------------------------------------
// vga_draw_pkg
// Shared definitions for the cell-painter slice: command op encodings, the
// painter FSM state type and the default playfield geometry.
// ---------------------------------------------------------------------------
package vga_draw_pkg;

    localparam logic OP_PAINT = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int DEF_CELL_W    = 16;
    localparam int DEF_CELL_H    = 16;
    localparam int DEF_GRID_COLS = 10;
    localparam int DEF_GRID_ROWS = 20;
    localparam int DEF_ORIGIN_X  = 240;
    localparam int DEF_ORIGIN_Y  = 80;

endpackage

// File: rtl/vga_rect_scanner.sv
// ---------------------------------------------------------------------------
// vga_rect_scanner
// Walks a width x height rectangle one pixel per cycle in row-major order.
// The first pixel is presented combinationally in the same cycle as start_i,
// so the caller can register it on the start edge itself.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             begin a scan (base and size sampled this cycle)
//   base_x_i, base_y_i  rectangle top-left
//   width_i, height_i   rectangle size in pixels (both >= 1)
//   dx_o, dy_o          offset of the current pixel inside the rectangle
//   px_o, py_o          absolute coordinate of the current pixel
//   valid_o             a pixel is presented this cycle
//   last_o              the presented pixel is the final one
// ---------------------------------------------------------------------------
module vga_rect_scanner #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [X_W-1:0] base_x_i,
    input  logic [Y_W-1:0] base_y_i,
    input  logic [X_W-1:0] width_i,
    input  logic [Y_W-1:0] height_i,
    output logic [X_W-1:0] dx_o,
    output logic [Y_W-1:0] dy_o,
    output logic [X_W-1:0] px_o,
    output logic [Y_W-1:0] py_o,
    output logic           valid_o,
    output logic           last_o
);

    logic           active_q;
    logic [X_W-1:0] dx_q, bx_q, w_q;
    logic [Y_W-1:0] dy_q, by_q, h_q;

    logic [X_W-1:0] cur_dx, cur_bx, cur_w;
    logic [Y_W-1:0] cur_dy, cur_by, cur_h;
    logic           cur_valid, end_of_row, cur_last;

    // start_i overrides the stored geometry so pixel 0 is available immediately
    always_comb begin
        cur_dx    = '0;
        cur_dy    = '0;
        cur_bx    = bx_q;
        cur_by    = by_q;
        cur_w     = w_q;
        cur_h     = h_q;
        cur_valid = 1'b0;
        if (start_i) begin
            cur_bx    = base_x_i;
            cur_by    = base_y_i;
            cur_w     = width_i;
            cur_h     = height_i;
            cur_valid = 1'b1;
        end else if (active_q) begin
            cur_dx    = dx_q;
            cur_dy    = dy_q;
            cur_valid = 1'b1;
        end
        end_of_row = (cur_dx == cur_w - X_W'(1));
        cur_last   = cur_valid && end_of_row && (cur_dy == cur_h - Y_W'(1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else if (cur_valid) begin
            active_q <= !cur_last;
            bx_q     <= cur_bx;
            by_q     <= cur_by;
            w_q      <= cur_w;
            h_q      <= cur_h;
            if (end_of_row) begin
                dx_q <= '0;
                dy_q <= cur_dy + Y_W'(1);
            end else begin
                dx_q <= cur_dx + X_W'(1);
                dy_q <= cur_dy;
            end
        end
    end

    assign dx_o    = cur_dx;
    assign dy_o    = cur_dy;
    assign px_o    = cur_bx + cur_dx;
    assign py_o    = cur_by + cur_dy;
    assign valid_o = cur_valid;
    assign last_o  = cur_last;

endmodule

// File: rtl/vga_cell_painter.sv
// ---------------------------------------------------------------------------
// vga_cell_painter
// Pixel-write engine feeding vga_adapter. Accepts one command at a time:
// paint a single grid cell (op 0) or clear the whole playfield (op 1), and
// emits one registered pixel write per cycle until the rectangle is done.
//
// Ports:
//   CLOCK_50, reset          clock, asynchronous active-high reset
//   req_valid / req_ready    command handshake (ready only when idle)
//   req_op, req_col, req_row command and target cell
//   req_color                fill colour
//   x, y, color, write       registered pixel interface to the adapter
//   done                     one-cycle completion pulse
//   err                      with done: command rejected (cell out of range)
//
// Build option: define VGA_CELL_BORDER_EN to outline painted cells with
// BORDER_COLOR; otherwise every pixel uses the requested colour.
// ---------------------------------------------------------------------------
module vga_cell_painter
    import vga_draw_pkg::*;
#(
    parameter int                     X_W          = 10,
    parameter int                     Y_W          = 9,
    parameter int                     COLOR_DEPTH  = 9,
    parameter int                     CELL_W       = DEF_CELL_W,
    parameter int                     CELL_H       = DEF_CELL_H,
    parameter int                     GRID_COLS    = DEF_GRID_COLS,
    parameter int                     GRID_ROWS    = DEF_GRID_ROWS,
    parameter int                     ORIGIN_X     = DEF_ORIGIN_X,
    parameter int                     ORIGIN_Y     = DEF_ORIGIN_Y,
    parameter logic [COLOR_DEPTH-1:0] BORDER_COLOR = '0
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_op,
    input  logic [$clog2(GRID_COLS)-1:0]  req_col,
    input  logic [$clog2(GRID_ROWS)-1:0]  req_row,
    input  logic [COLOR_DEPTH-1:0]        req_color,
    output logic [X_W-1:0]                x,
    output logic [Y_W-1:0]                y,
    output logic [COLOR_DEPTH-1:0]        color,
    output logic                          write,
    output logic                          done,
    output logic                          err
);

    localparam int                C_W      = $clog2(GRID_COLS);
    localparam int                R_W      = $clog2(GRID_ROWS);
    localparam logic [C_W:0]      COLS_LIM = (C_W+1)'(GRID_COLS);
    localparam logic [R_W:0]      ROWS_LIM = (R_W+1)'(GRID_ROWS);

    state_e                 state_q, state_d;
    logic                   op_q, err_q;
    logic [COLOR_DEPTH-1:0] cmd_color_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic [COLOR_DEPTH-1:0] pix_color_q, pix_color;
    logic                   write_q, last_q;

    logic                   accept, out_of_range, start;
    logic [X_W-1:0]         base_x, size_w;
    logic [Y_W-1:0]         base_y, size_h;
    logic [COLOR_DEPTH-1:0] sel_color;

    logic [X_W-1:0]         scan_dx, scan_px;
    logic [Y_W-1:0]         scan_dy, scan_py;
    logic                   scan_valid, scan_last;

    assign accept       = req_valid && (state_q == IDLE);
    assign out_of_range = (req_op == OP_PAINT) &&
                          (({1'b0, req_col} >= COLS_LIM) || ({1'b0, req_row} >= ROWS_LIM));
    assign start        = accept && !out_of_range;

    always_comb begin
        base_x = X_W'(ORIGIN_X);
        base_y = Y_W'(ORIGIN_Y);
        size_w = X_W'(GRID_COLS * CELL_W);
        size_h = Y_W'(GRID_ROWS * CELL_H);
        if (req_op == OP_PAINT) begin
            base_x = X_W'(ORIGIN_X + CELL_W * int'(req_col));
            base_y = Y_W'(ORIGIN_Y + CELL_H * int'(req_row));
            size_w = X_W'(CELL_W);
            size_h = Y_W'(CELL_H);
        end
    end

    vga_rect_scanner #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk_i    (CLOCK_50),
        .rst_i    (reset),
        .start_i  (start),
        .base_x_i (base_x),
        .base_y_i (base_y),
        .width_i  (size_w),
        .height_i (size_h),
        .dx_o     (scan_dx),
        .dy_o     (scan_dy),
        .px_o     (scan_px),
        .py_o     (scan_py),
        .valid_o  (scan_valid),
        .last_o   (scan_last)
    );

    // Pixel 0 is produced on the accept cycle, before the command is latched,
    // so colour/op come straight from the request on that cycle.
    assign sel_color = accept ? req_color : cmd_color_q;

`ifdef VGA_CELL_BORDER_EN
    logic sel_op;
    assign sel_op = accept ? req_op : op_q;

    always_comb begin
        pix_color = sel_color;
        if (sel_op == OP_PAINT &&
            (scan_dx == '0 || scan_dx == X_W'(CELL_W - 1) ||
             scan_dy == '0 || scan_dy == Y_W'(CELL_H - 1))) begin
            pix_color = BORDER_COLOR;
        end
    end
`else
    logic unused_border;
    assign unused_border = ^{BORDER_COLOR, scan_dx, scan_dy, op_q};
    assign pix_color     = sel_color;
`endif

    // A rejected command still spends one DRAW cycle, so done/err land two
    // cycles after acceptance, same as a zero-length rectangle would.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DRAW;
            DRAW:    if (err_q || (write_q && last_q)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PAINT;
            err_q       <= 1'b0;
            cmd_color_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_color_q <= '0;
            write_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q        <= req_op;
                err_q       <= out_of_range;
                cmd_color_q <= req_color;
            end
            write_q <= scan_valid;
            last_q  <= scan_valid && scan_last;
            if (scan_valid) begin
                x_q         <= scan_px;
                y_q         <= scan_py;
                pix_color_q <= pix_color;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign x         = x_q;
    assign y         = y_q;
    assign color     = pix_color_q;
    assign write     = write_q;
    assign done      = (state_q == FIN);
    assign err       = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_vga_cell_painter.sv
// ---------------------------------------------------------------------------
// tb_vga_cell_painter
// Scoreboard bench: the driver issues commands and, at acceptance, expands
// each into the list of pixels (with the cycle each must appear) and the
// expected completion event. A monitor on the falling edge pops and compares
// every write and every done pulse.
// ---------------------------------------------------------------------------
module tb_vga_cell_painter;

    localparam int X_W         = 10;
    localparam int Y_W         = 9;
    localparam int COLOR_DEPTH = 9;
    localparam int CELL_W      = 16;
    localparam int CELL_H      = 16;
    localparam int GRID_COLS   = 10;
    localparam int GRID_ROWS   = 20;
    localparam int ORIGIN_X    = 240;
    localparam int ORIGIN_Y    = 80;
    localparam int C_W         = $clog2(GRID_COLS);
    localparam int R_W         = $clog2(GRID_ROWS);
    localparam logic [COLOR_DEPTH-1:0] BORDER = 9'h1FF;
    localparam int BOUND       = 60000;

    logic                   CLOCK_50 = 1'b0;
    logic                   reset;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_op;
    logic [C_W-1:0]         req_col;
    logic [R_W-1:0]         req_row;
    logic [COLOR_DEPTH-1:0] req_color;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [COLOR_DEPTH-1:0] color;
    logic                   write;
    logic                   done;
    logic                   err;

    vga_cell_painter #(
        .X_W          (X_W),
        .Y_W          (Y_W),
        .COLOR_DEPTH  (COLOR_DEPTH),
        .CELL_W       (CELL_W),
        .CELL_H       (CELL_H),
        .GRID_COLS    (GRID_COLS),
        .GRID_ROWS    (GRID_ROWS),
        .ORIGIN_X     (ORIGIN_X),
        .ORIGIN_Y     (ORIGIN_Y),
        .BORDER_COLOR (BORDER)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_col   (req_col),
        .req_row   (req_row),
        .req_color (req_color),
        .x         (x),
        .y         (y),
        .color     (color),
        .write     (write),
        .done      (done),
        .err       (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int     px;
        int     py;
        int     pc;
        longint at;
    } pix_t;

    typedef struct {
        bit     e;
        longint at;
    } done_t;

    pix_t   pq[$];
    done_t  dq[$];
    int     checks = 0;
    int     errors = 0;
    int     wr_seen = 0;
    longint cyc = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Reference model: expand a command accepted on edge 'acc' into its pixels.
    task automatic expect_cmd(input bit op, input int col, input int row,
                              input int c, input longint acc);
        int bx, by, w, h, pc;
        if (op == 1'b0 && (col >= GRID_COLS || row >= GRID_ROWS)) begin
            dq.push_back('{1'b1, acc + 1});
            return;
        end
        if (op == 1'b0) begin
            bx = ORIGIN_X + col * CELL_W;
            by = ORIGIN_Y + row * CELL_H;
            w  = CELL_W;
            h  = CELL_H;
        end else begin
            bx = ORIGIN_X;
            by = ORIGIN_Y;
            w  = GRID_COLS * CELL_W;
            h  = GRID_ROWS * CELL_H;
        end
        for (int dy = 0; dy < h; dy++) begin
            for (int dx = 0; dx < w; dx++) begin
                pc = c;
`ifdef VGA_CELL_BORDER_EN
                if (op == 1'b0 && (dx == 0 || dx == w - 1 || dy == 0 || dy == h - 1))
                    pc = int'(BORDER);
`endif
                pq.push_back('{bx + dx, by + dy, pc, acc + longint'(dy * w + dx)});
            end
        end
        dq.push_back('{1'b0, acc + longint'(w * h)});
    endtask

    // Monitor
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (write) begin
                chk("ready_low_while_writing", req_ready, 0);
                if (pq.size() == 0) begin
                    fail("unexpected_write", $sformatf("write at (%0d,%0d) with nothing expected", x, y));
                end else begin
                    pix_t p;
                    p = pq.pop_front();
                    chk("pix_cycle", cyc, p.at);
                    chk("pix_x", x, p.px);
                    chk("pix_y", y, p.py);
                    chk("pix_color", color, p.pc);
                    wr_seen++;
                end
            end
            if (done) begin
                chk("write_low_at_done", write, 0);
                if (dq.size() == 0) begin
                    fail("unexpected_done", "done pulse with no command outstanding");
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.at);
                    chk("err_flag", err, d.e);
                    chk("pixels_missing_at_done", pq.size(), 0);
                end
            end else if (err) begin
                fail("err_without_done", "err high while done low");
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input bit op, input int col, input int row, input int c);
        int n;
        req_op    = op;
        req_col   = C_W'(col);
        req_row   = R_W'(row);
        req_color = COLOR_DEPTH'(c);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!req_ready) begin
            fail("ready_timeout", "req_ready never rose");
            req_valid = 1'b0;
            return;
        end
        expect_cmd(op, col, row, c, cyc + 1);
        @(negedge CLOCK_50);
        req_valid = 1'b0;
        // scramble inputs: the latched command must not follow them
        req_op    = 1'($urandom);
        req_col   = C_W'($urandom);
        req_row   = R_W'($urandom);
        req_color = COLOR_DEPTH'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pq.size() != 0 || dq.size() != 0) && n < BOUND) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (pq.size() != 0 || dq.size() != 0)
            fail("drain_timeout", $sformatf("%0d pixels / %0d done events outstanding", pq.size(), dq.size()));
        @(negedge CLOCK_50);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_col   = '0;
        req_row   = '0;
        req_color = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ready", req_ready, 1);
        chk("rst_write", write, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_color", color, 0);
        reset = 1'b0;
        @(negedge CLOCK_50);

        // directed commands, issued back-to-back with valid held while busy
        send(1'b0, 0, 0, 'h1C0);
        send(1'b0, 9, 19, 'h0F3);
        send(1'b1, 0, 0, 'h000);
        send(1'b0, 10, 0, 'h155);
        send(1'b0, 0, 20, 'h0AA);
        send(1'b0, 1, 2, 'h03C);
        wait_idle();

        // randomized paints, including out-of-range cells
        repeat (16) begin
            send(1'b0, int'($urandom_range(0, GRID_COLS)), int'($urandom_range(0, GRID_ROWS)),
                 int'($urandom_range(0, 511)));
            repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        end
        wait_idle();

        // reset during the 100th write of a paint
        wr_seen = 0;
        send(1'b0, 3, 4, 'h1A5);
        n = 0;
        while (wr_seen < 100 && n < 1000) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        if (wr_seen < 100) fail("reset_test_timeout", "100th write never seen");
        #1 reset = 1'b1;
        #1;
        chk("midreset_write", write, 0);
        chk("midreset_ready", req_ready, 1);
        chk("midreset_done", done, 0);
        pq.delete();
        dq.delete();
        @(negedge CLOCK_50);
        #1 reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        send(1'b0, 5, 6, 'h123);
        wait_idle();

        repeat (5) @(negedge CLOCK_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_cell_painter.md
Name: vga_cell_painter

Overview:
- Sequential pixel-write engine that sits between game logic and vga_adapter; drives the adapter's x/y/color/write inputs, which until now have been tied off.
- Accepts one command at a time over a valid/ready handshake:
  - Paint one Tetris grid cell as a solid CELL_W x CELL_H block at a grid (col,row).
  - Clear the whole playfield rectangle to one color.
- Parametrised in resolution widths, colour depth, cell size, grid size and playfield origin.

Parameters:
- X_W, 10: width of x output (640-wide mode).
- Y_W, 9: width of y output.
- COLOR_DEPTH, 9: colour bits, must match adapter COLOR_DEPTH.
- CELL_W, 16: cell width in pixels, >=2.
- CELL_H, 16: cell height in pixels, >=2.
- GRID_COLS, 10: playfield columns.
- GRID_ROWS, 20: playfield rows.
- ORIGIN_X, 240: pixel x of playfield top-left.
- ORIGIN_Y, 80: pixel y of playfield top-left.
- BORDER_COLOR, 9'h000: outline colour, used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  block idle and able to accept.
- req_op  in  1  0 = paint cell, 1 = clear playfield.
- req_col  in  $clog2(GRID_COLS)  cell column (op 0).
- req_row  in  $clog2(GRID_ROWS)  cell row (op 0).
- req_color  in  COLOR_DEPTH  fill colour.
- x  out  X_W  pixel x to adapter.
- y  out  Y_W  pixel y to adapter.
- color  out  COLOR_DEPTH  pixel colour to adapter.
- write  out  1  pixel write strobe to adapter.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse with done if the command was rejected.

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; write=0; done=0; err=0; x=0; y=0; color=0. A reset mid-draw abandons the command; no further writes are issued.
- States: IDLE, DRAW, FIN.
- Handshake:
  - Accept on the rising edge where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - The op, coordinates and colour are latched at acceptance; inputs are ignored afterwards.
- Paint (op 0):
  - Base point: bx = ORIGIN_X + col*CELL_W, by = ORIGIN_Y + row*CELL_H, computed in X_W/Y_W bits.
  - Parameter choice must keep the playfield inside the resolution; no wrap checking in RTL.
  - Scan is row-major: dx runs 0..CELL_W-1 inside dy 0..CELL_H-1.
- Clear (op 1): same scan over GRID_COLS*CELL_W by GRID_ROWS*CELL_H pixels from (ORIGIN_X, ORIGIN_Y).
- DRAW output timing:
  - Exactly one pixel per cycle, with x, y, color and write all registered.
  - First write is asserted the cycle after acceptance.
  - Writes are contiguous with no bubbles.
  - The pixel count is CELL_W*CELL_H for paint and the full playfield area for clear.
- Completion:
  - After the last write cycle the block enters FIN: write=0, done=1 for exactly one cycle.
  - It then returns to IDLE with req_ready=1 in the following cycle.
  - Paint latency, acceptance edge to done: CELL_W*CELL_H + 1 cycles.
- Out-of-range request: op 0 with col>=GRID_COLS or row>=GRID_ROWS is accepted but issues no writes. The block goes straight to FIN with done=1 and err=1, then IDLE.
- req_valid held high while busy: the command is held off and accepted only in IDLE. Back-to-back commands are separated by the FIN cycle and the IDLE cycle.
- While write=0, x, y and color hold their last values.

Optional Feature:
- Macro: VGA_CELL_BORDER_EN.
- Defined: in op 0, pixels with dx==0, dx==CELL_W-1, dy==0 or dy==CELL_H-1 use BORDER_COLOR; interior pixels use req_color. Op 1 is unaffected.
- Undefined: every pixel uses req_color; BORDER_COLOR is unused.

Decomposition:
- Package vga_draw_pkg holds:
  - op encodings OP_PAINT = 1'b0 and OP_CLEAR = 1'b1;
  - state enum IDLE/DRAW/FIN;
  - default geometry constants (cell size, grid size, origin).
- One sub-module, vga_rect_scanner:
  - Inputs: start, base x/y, width, height.
  - Outputs: per-cycle dx/dy, valid and last.
  - The top FSM reuses it for both paint and clear.

Test Plan:
- Reset, then paint col=0, row=0, color=9'h1C0 -> 256 contiguous writes from (240,80) to (255,95), row-major; done one cycle after the last write; req_ready=0 throughout.
- Paint col=9, row=19 -> first write (384,384), last (399,399); no write outside this block.
- Clear with color=9'h000 -> 51200 writes covering x 240..399, y 80..399; then done.
- Paint col=10 -> zero writes; done=1 and err=1 on the same cycle, two cycles after acceptance.
- Assert reset during the 100th write of a paint -> write drops immediately, state IDLE; a new paint is then accepted normally.
- With VGA_CELL_BORDER_EN and BORDER_COLOR=9'h1FF, paint col=1, row=2 -> pixel (256,112) is 1FF, (257,113) is req_color, (271,127) is 1FF.
